// File: rtl/lc4_wb_stage.sv
// lc4_wb_stage: LC4 writeback stage.
// Completed results enter through a valid/ready handshake and wait in a
// 2-entry skid FIFO. They retire in order to the register-file write port,
// and each retiring register write updates the NZP condition codes.
// in_ready depends only on registered occupancy, so wb_stall does not
// reach upstream through a combinational path.
// Optional feature: define LC4_WB_TRACE_EN to enable trace_valid, trace_pc
// and retire_count. Without it these outputs are tied to zero and the pc
// field is not stored.
module lc4_wb_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pc,
  input  logic [2:0]  in_rd,
  input  logic        in_regfile_we,
  input  logic [15:0] in_rddata,
  input  logic        flush,
  input  logic        wb_stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [2:0]  wb_sel,
  output logic [15:0] wb_data,
  output logic [2:0]  nzp,
  output logic        trace_valid,
  output logic [15:0] trace_pc,
  output logic [15:0] retire_count
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  logic [1:0]  count;
  logic        head;
  logic        tail;
  logic [2:0]  rd_q   [2];
  logic        we_q   [2];
  logic [15:0] data_q [2];

  logic push;
  logic pop;

  // Handshake and head-of-queue view
  always_comb begin
    in_ready = (count != FULL_COUNT);
    wb_valid = (count != 2'd0);
    wb_sel   = rd_q[head];
    wb_data  = data_q[head];
    push     = in_valid && in_ready && !flush;
    pop      = wb_valid && !wb_stall && !flush;
    // Reset overrides everything, so no write escapes in a reset cycle.
    wb_we    = pop && we_q[head] && rst_n;
  end

  // Entry storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= in_rd;
      we_q[tail]   <= in_regfile_we;
      data_q[tail] <= in_rddata;
    end
  end

  // Pointers, occupancy and architectural condition codes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      nzp   <= 3'b010;
    end else if (flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        if (we_q[head]) begin
          nzp <= {data_q[head][15],
                  (data_q[head] == 16'h0000),
                  (!data_q[head][15] && (data_q[head] != 16'h0000))};
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef LC4_WB_TRACE_EN
  logic [15:0] pc_q [2];

  // PC storage for the retirement trace
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail] <= in_pc;
    end
  end

  // Retirement trace, visible in the same cycle as the pop
  always_comb begin
    trace_valid = pop && rst_n;
    trace_pc    = pc_q[head];
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (pop) begin
      retire_count <= retire_count + 16'd1;
    end
  end
`else
  logic [15:0] unused_pc;

  // Trace disabled: outputs held at zero, pc input ignored
  always_comb begin
    unused_pc    = in_pc;
    trace_valid  = 1'b0;
    trace_pc     = '0;
    retire_count = '0;
  end
`endif

endmodule

// File: tb/tb_lc4_wb_stage.sv
// tb_lc4_wb_stage: directed bench for lc4_wb_stage.
// Trace expectations follow LC4_WB_TRACE_EN as seen by this file.
module tb_lc4_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [2:0]  in_rd;
  logic        in_regfile_we;
  logic [15:0] in_rddata;
  logic        flush;
  logic        wb_stall;
  logic        wb_valid;
  logic        wb_we;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic [2:0]  nzp;
  logic        trace_valid;
  logic [15:0] trace_pc;
  logic [15:0] retire_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  lc4_wb_stage #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_rd         (in_rd),
    .in_regfile_we (in_regfile_we),
    .in_rddata     (in_rddata),
    .flush         (flush),
    .wb_stall      (wb_stall),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_sel        (wb_sel),
    .wb_data       (wb_data),
    .nzp           (nzp),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic [2:0] rd,
                       input logic we, input logic [15:0] d);
    in_valid      = v;
    in_pc         = pc;
    in_rd         = rd;
    in_regfile_we = we;
    in_rddata     = d;
    #1;
  endtask

  task automatic chk_trace(input string tag, input logic tv, input logic [15:0] tpc);
`ifdef LC4_WB_TRACE_EN
    chk({tag, "_tv"}, 32'(trace_valid), 32'(tv));
    if (tv) chk({tag, "_tpc"}, 32'(trace_pc), 32'(tpc));
`else
    chk({tag, "_tv"}, 32'(trace_valid), 32'h0);
    chk({tag, "_tpc"}, 32'(trace_pc), 32'h0);
`endif
  endtask

  task automatic chk_rc(input string tag, input logic [15:0] exp);
`ifdef LC4_WB_TRACE_EN
    chk(tag, 32'(retire_count), 32'(exp));
`else
    chk(tag, 32'(retire_count), 32'h0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_stall = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    tick(); tick();
    rst_n = 1'b1; #1;

    // Reset state
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_valid", 32'(wb_valid), 32'h0);
    chk("rst_we",    32'(wb_we),    32'h0);
    chk("rst_nzp",   32'(nzp),      32'h2);
    chk_trace("rst", 1'b0, 16'h0);
    chk_rc("rst_rc", 16'h0);

    // Single negative write
    drive(1'b1, 16'h0010, 3'd3, 1'b1, 16'h8001);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    chk("t1_valid", 32'(wb_valid), 32'h1);
    chk("t1_we",    32'(wb_we),    32'h1);
    chk("t1_sel",   32'(wb_sel),   32'h3);
    chk("t1_data",  32'(wb_data),  32'h8001);
    chk("t1_nzp0",  32'(nzp),      32'h2);
    chk_trace("t1", 1'b1, 16'h0010);
    tick();
    chk("t1_nzp",   32'(nzp),      32'h4);
    chk("t1_empty", 32'(wb_valid), 32'h0);

    // Zero write then non-writing instruction, back to back
    drive(1'b1, 16'h0020, 3'd1, 1'b1, 16'h0000);
    tick();
    drive(1'b1, 16'h0021, 3'd2, 1'b0, 16'h0005);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    chk("t2_nzp1",  32'(nzp),      32'h2);
    chk("t2_valid", 32'(wb_valid), 32'h1);
    chk("t2_we",    32'(wb_we),    32'h0);
    chk("t2_data",  32'(wb_data),  32'h0005);
    chk_trace("t2", 1'b1, 16'h0021);
    tick();
    chk("t2_nzp2",  32'(nzp),      32'h2);
    chk("t2_empty", 32'(wb_valid), 32'h0);

    // Positive write
    drive(1'b1, 16'h0022, 3'd5, 1'b1, 16'h7FFF);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    tick();
    chk("tp_nzp", 32'(nzp), 32'h1);

    // Stall with three back-to-back pushes
    wb_stall = 1'b1;
    drive(1'b1, 16'h0030, 3'd1, 1'b1, 16'h1111);
    chk("t3_we_a", 32'(wb_we), 32'h0);
    tick();
    drive(1'b1, 16'h0031, 3'd2, 1'b1, 16'h2222);
    chk("t3_rdy_b", 32'(in_ready), 32'h1);
    chk("t3_we_b",  32'(wb_we),    32'h0);
    tick();
    drive(1'b1, 16'h0032, 3'd4, 1'b1, 16'h0000);
    chk("t3_rdy_c",  32'(in_ready), 32'h0);
    chk("t3_we_c",   32'(wb_we),    32'h0);
    chk("t3_sel_c",  32'(wb_sel),   32'h1);
    tick();
    chk("t3_rdy_c2", 32'(in_ready), 32'h0);
    chk("t3_we_c2",  32'(wb_we),    32'h0);
    wb_stall = 1'b0; #1;
    chk("t3_rdy_rel", 32'(in_ready), 32'h0);
    chk("t3_we_a1",   32'(wb_we),    32'h1);
    chk("t3_sel_a1",  32'(wb_sel),   32'h1);
    chk("t3_dat_a1",  32'(wb_data),  32'h1111);
    tick();
    chk("t3_rdy_b1", 32'(in_ready), 32'h1);
    chk("t3_we_b1",  32'(wb_we),    32'h1);
    chk("t3_sel_b1", 32'(wb_sel),   32'h2);
    chk("t3_dat_b1", 32'(wb_data),  32'h2222);
    chk("t3_nzp_a",  32'(nzp),      32'h1);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    chk("t3_sel_c1", 32'(wb_sel),   32'h4);
    chk("t3_we_cc",  32'(wb_we),    32'h1);
    chk_trace("t3", 1'b1, 16'h0032);
    tick();
    chk("t3_nzp_c",  32'(nzp),      32'h2);
    chk("t3_empty",  32'(wb_valid), 32'h0);

    // Flush with a full FIFO and a pending push
    wb_stall = 1'b1;
    drive(1'b1, 16'h0040, 3'd6, 1'b1, 16'h8000);
    tick();
    drive(1'b1, 16'h0041, 3'd7, 1'b1, 16'h0009);
    tick();
    chk("t4_full", 32'(in_ready), 32'h0);
    wb_stall = 1'b0; flush = 1'b1;
    drive(1'b1, 16'h0042, 3'd5, 1'b1, 16'h8888);
    chk("t4_we_fl", 32'(wb_we), 32'h0);
    chk_trace("t4_fl", 1'b0, 16'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    chk("t4_valid", 32'(wb_valid), 32'h0);
    chk("t4_ready", 32'(in_ready), 32'h1);
    chk("t4_we",    32'(wb_we),    32'h0);
    chk("t4_nzp",   32'(nzp),      32'h2);
    chk_rc("t4_rc", 16'd7);
    tick();
    chk("t4_valid2", 32'(wb_valid), 32'h0);

`ifdef LC4_WB_TRACE_EN
    // Drive retire_count to 16'hFFFF, then wrap
    drive(1'b1, 16'h0100, 3'd0, 1'b0, 16'h0001);
    for (int i = 0; i < 65528; i++) tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    tick();
    chk("t5_rc_max", 32'(retire_count), 32'hFFFF);
    drive(1'b1, 16'hBEEF, 3'd2, 1'b0, 16'h0003);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    chk("t5_tv",  32'(trace_valid), 32'h1);
    chk("t5_tpc", 32'(trace_pc),    32'hBEEF);
    tick();
    chk("t5_rc_wrap", 32'(retire_count), 32'h0);
    chk("t5_tv0",     32'(trace_valid),  32'h0);
`endif

    // Reset mid-stream with one writing entry queued
    drive(1'b1, 16'h0050, 3'd1, 1'b1, 16'h8000);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    tick();
    chk("t6_nzp_pre", 32'(nzp), 32'h4);
    drive(1'b1, 16'h0051, 3'd2, 1'b1, 16'h0001);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
    wb_stall = 1'b0; rst_n = 1'b0; #1;
    chk("t6_we_rst", 32'(wb_we), 32'h0);
    chk_trace("t6_rst", 1'b0, 16'h0);
    tick();
    rst_n = 1'b1; #1;
    chk("t6_valid", 32'(wb_valid), 32'h0);
    chk("t6_we",    32'(wb_we),    32'h0);
    chk("t6_nzp",   32'(nzp),      32'h2);
    chk("t6_ready", 32'(in_ready), 32'h1);
    chk_rc("t6_rc", 16'h0);
    tick();
    chk("t6_we2",  32'(wb_we), 32'h0);
    chk("t6_nzp2", 32'(nzp),   32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
